// File: rtl/param_alu_unit_if.sv
// Operand/result channel for param_alu_unit: valid/ready on both sides, plus a busy status.
// The producer side (master) drives operands and result-ready; the ALU (slave) drives the rest.
interface param_alu_unit_if #(
  parameter int WIDTH = 16
);
  logic             in_vld;
  logic             in_rdy;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op_sel;
  logic             wf;
  logic             out_vld;
  logic             out_rdy;
  logic [WIDTH-1:0] alu_out;
  logic [3:0]       flags_out;
  logic             busy;

  modport master (
    output in_vld, a, b, op_sel, wf, out_rdy,
    input  in_rdy, out_vld, alu_out, flags_out, busy
  );

  modport slave (
    input  in_vld, a, b, op_sel, wf, out_rdy,
    output in_rdy, out_vld, alu_out, flags_out, busy
  );
endinterface

// File: rtl/param_alu_unit.sv
// Handshaked ALU with {Z,C,N,O} flags: single-cycle ops land at the transfer edge, MUL WIDTH edges later.
// Input is refused while a MUL runs or the output register holds an unpopped result.
module param_alu_unit #(
  parameter int WIDTH = 16
) (
  input logic              i_clk,
  input logic              i_rst_n,
  param_alu_unit_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0]   W_SH   = (SHW+1)'(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  localparam logic [3:0] OP_PASSA = 4'd0;
  localparam logic [3:0] OP_PASSB = 4'd1;
  localparam logic [3:0] OP_NOTA  = 4'd2;
  localparam logic [3:0] OP_NOTB  = 4'd3;
  localparam logic [3:0] OP_ADD   = 4'd4;
  localparam logic [3:0] OP_ADC   = 4'd5;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_AND   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_XOR   = 4'd9;
  localparam logic [3:0] OP_NAND  = 4'd10;
  localparam logic [3:0] OP_LSL   = 4'd11;
  localparam logic [3:0] OP_LSR   = 4'd12;
  localparam logic [3:0] OP_ASR   = 4'd13;
  localparam logic [3:0] OP_ROL   = 4'd14;
  localparam logic [3:0] OP_MUL   = 4'd15;

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e             r_state;
  logic [WIDTH-1:0]   r_alu_out;
  logic [3:0]         r_flags;
  logic               r_out_vld;
  logic               r_busy;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [SHW-1:0]     r_cnt;
  logic               r_wf;

  logic               w_pop;
  logic               w_xfer;
  logic [SHW-1:0]     w_n;
  logic [SHW:0]       w_rsh;
  logic               w_sub;
  logic               w_cin;
  logic [WIDTH-1:0]   w_b_add;
  logic [WIDTH:0]     w_sum;
  logic               w_o_add;
  logic [WIDTH:0]     w_lsl;
  logic [WIDTH:0]     w_lsr;
  logic [WIDTH:0]     w_asr;
  logic [WIDTH-1:0]   w_rol;
  logic [WIDTH-1:0]   w_res;
  logic               w_c_new;
  logic               w_o_new;
  logic [3:0]         w_flags;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [3:0]         w_mul_flags;

  assign bus.in_rdy    = (r_state == S_IDLE) && (!r_out_vld || bus.out_rdy);
  assign bus.out_vld   = r_out_vld;
  assign bus.alu_out   = r_alu_out;
  assign bus.flags_out = r_flags;
  assign bus.busy      = r_busy;

  assign w_pop  = r_out_vld && bus.out_rdy;
  assign w_xfer = bus.in_vld && bus.in_rdy;
  assign w_n    = bus.b[SHW-1:0];
  assign w_rsh  = W_SH - {1'b0, w_n};

  // SUB is A + ~B + 1, so one adder serves ADD/ADC/SUB and C is a plain carry-out.
  assign w_sub   = (bus.op_sel == OP_SUB);
  assign w_b_add = w_sub ? ~bus.b : bus.b;
  assign w_cin   = w_sub | ((bus.op_sel == OP_ADC) & r_flags[2]);
  assign w_sum   = {1'b0, bus.a} + {1'b0, w_b_add} + {{WIDTH{1'b0}}, w_cin};
  assign w_o_add = (bus.a[WIDTH-1] == w_b_add[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);

  // One guard bit on each shifter catches the last bit shifted out.
  assign w_lsl = {1'b0, bus.a} << w_n;
  assign w_lsr = {bus.a, 1'b0} >> w_n;
  assign w_asr = $signed({bus.a, 1'b0}) >>> w_n;
  assign w_rol = (bus.a << w_n) | (bus.a >> w_rsh);

  always_comb begin
    w_res   = '0;
    w_c_new = r_flags[2];
    w_o_new = r_flags[0];
    case (bus.op_sel)
      OP_PASSA: w_res = bus.a;
      OP_PASSB: w_res = bus.b;
      OP_NOTA:  w_res = ~bus.a;
      OP_NOTB:  w_res = ~bus.b;
      OP_ADD, OP_ADC, OP_SUB: begin
        w_res   = w_sum[WIDTH-1:0];
        w_c_new = w_sum[WIDTH];
        w_o_new = w_o_add;
      end
      OP_AND:   w_res = bus.a & bus.b;
      OP_OR:    w_res = bus.a | bus.b;
      OP_XOR:   w_res = bus.a ^ bus.b;
      OP_NAND:  w_res = ~(bus.a & bus.b);
      OP_LSL: begin
        w_res = w_lsl[WIDTH-1:0];
        if (w_n != '0) w_c_new = w_lsl[WIDTH];
      end
      OP_LSR: begin
        w_res = w_lsr[WIDTH:1];
        if (w_n != '0) w_c_new = w_lsr[0];
      end
      OP_ASR: begin
        w_res = w_asr[WIDTH:1];
        if (w_n != '0) w_c_new = w_asr[0];
      end
      OP_ROL: begin
        w_res = w_rol;
        if (w_n != '0) w_c_new = w_rol[0];
      end
      default: w_res = '0;
    endcase
    w_flags = {(w_res == '0), w_c_new, w_res[WIDTH-1], w_o_new};
  end

  // Shift-add step: the last step's sum goes straight to the output register.
  assign w_acc_nxt   = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_flags = {(w_acc_nxt[WIDTH-1:0] == '0), |w_acc_nxt[2*WIDTH-1:WIDTH],
                        w_acc_nxt[WIDTH-1], r_flags[0]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_alu_out <= '0;
      r_flags   <= '0;
      r_out_vld <= 1'b0;
      r_busy    <= 1'b0;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_wf      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            if (bus.op_sel == OP_MUL) begin
              r_state   <= S_MUL;
              r_busy    <= 1'b1;
              r_mcand   <= {{WIDTH{1'b0}}, bus.a};
              r_mplier  <= bus.b;
              r_acc     <= '0;
              r_cnt     <= '0;
              r_wf      <= bus.wf;
              // Transfer implies the old result was absent or popped this edge.
              r_out_vld <= 1'b0;
            end else begin
              r_alu_out <= w_res;
              if (bus.wf) r_flags <= w_flags;
              r_out_vld <= 1'b1;
            end
          end else if (w_pop) begin
            r_out_vld <= 1'b0;
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + SHW'(1);
          if (r_cnt == CNT_LAST) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_alu_out <= w_acc_nxt[WIDTH-1:0];
            if (r_wf) r_flags <= w_mul_flags;
            r_out_vld <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/param_alu_unit.md
# param_alu_unit

Parametrised, handshaked successor to the 16-bit ALU. It takes operands over a valid/ready input channel and returns the result and Z/C/N/O flags over a valid/ready output channel. It adds variable-amount shifts/rotates and an iterative multi-cycle multiply. It sits between the register file read ports and the writeback path of the datapath.

## Interface
- WIDTH, 16: operand/result width, ≥4, power of two
- SHW, $clog2(WIDTH): shift-amount field width (derived, not overridden)

- Clock  in  1  system clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-low; clears all state
- InValid  in  1  operands/opcode valid
- InReady  out  1  block can accept; transfer when InValid && InReady at a rising edge
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B (shift amount = B[SHW-1:0])
- OpSel  in  4  operation select
- WF  in  1  write flags for this operation
- OutValid  out  1  ALUOut/FlagsOut hold a new result
- OutReady  in  1  consumer accepts result; pop when OutValid && OutReady
- ALUOut  out  WIDTH  registered result
- FlagsOut  out  4  registered {Z,C,N,O} ([3]=Z, [2]=C, [1]=N, [0]=O)
- Busy  out  1  multiply in progress

## Operation
- OpSel: 0 A, 1 B, 2 ~A, 3 ~B, 4 A+B, 5 A+B+C, 6 A−B, 7 A&B, 8 A|B, 9 A^B, 10 ~(A&B), 11 LSL, 12 LSR, 13 ASR, 14 ROL, 15 MUL (unsigned, low WIDTH bits).
- Arithmetic is modulo 2^WIDTH. Subtraction is computed as A + ~B + 1. For SUB, C = carry out of that sum (1 = no borrow).
- ADD/ADC/SUB: C = carry out. O = operands of equal sign (B inverted for SUB) and result sign differs from A.
- Shifts/rotates by n = B[SHW-1:0]:
  - For n≠0, C = last bit shifted out. For ROL, C = the new bit 0.
  - For n=0: result = A, C unchanged.
  - ASR replicates A[WIDTH-1]. O is unchanged for all shifts.
- MUL: C = 1 if the upper WIDTH bits of the full product are nonzero. O is unchanged.
- Ops 0–3 and 7–10: C and O unchanged.
- All ops: Z = (ALUOut == 0), N = ALUOut[WIDTH-1].
- FlagsOut updates only when WF was 1 at transfer; otherwise it holds. ALUOut always updates.
- ADC uses FlagsOut[2] as registered at the transfer edge. Back-to-back ops therefore see the previous op's carry.
- States:
  - IDLE: single-cycle ops complete here.
  - MUL: shift-add, one multiplier bit per cycle, WIDTH iterations.
- InReady = (state == IDLE) && (!OutValid || OutReady).

## Timing
- Reset values: ALUOut = 0, FlagsOut = 4'b0000, OutValid = 0, Busy = 0, state = IDLE. InReady is 1 after Reset deasserts.
- Single-cycle op transferred at edge k: ALUOut, FlagsOut and OutValid are set at edge k. Throughput is 1 op/cycle when OutReady is held high.
- MUL transferred at edge k:
  - A, B and WF are captured; Busy = 1 from edge k.
  - Result, flags and OutValid are set at edge k+WIDTH; Busy = 0 at that edge.
  - InReady stays 0 through edge k+WIDTH.
- Output stall (OutValid && !OutReady): InReady = 0. ALUOut/FlagsOut are held stable; no new transfer occurs.
- Pop without a new transfer at the same edge: OutValid → 0; ALUOut/FlagsOut are held.
- Pop and transfer at the same edge: OutValid stays 1 and new data is loaded.
- An MUL completion can only occur when the output register is empty or popping, because InReady gated its start.
- Reset asserted mid-MUL aborts the operation: no result, flags cleared. Reset asserted while OutValid is set drops the pending result.
- Input changes while InReady = 0 are ignored.

## Test plan
- Reset, then ADD A=0x7FFF B=0x0001 WF=1 → ALUOut 0x8000, FlagsOut 4'b0011 (Z=0, C=0, N=1, O=1) at the transfer edge.
- SUB 0x0005−0x0005 WF=1, then ADC 0x0001+0x0001 back-to-back → first result 0x0000 flags 4'b1100; second result 0x0003 (C=1 carried in).
- LSR A=0x8001 n=1 → 0x4000, C=1. ASR A=0x8000 n=15 → 0xFFFF, N=1. ROL A=0x8000 n=1 → 0x0001, C=1. Any shift with n=0 → C unchanged.
- MUL 0x0100×0x0100 WF=1 → InReady low for 16 cycles, Busy high; result 0x0000 at edge k+16 with Z=1, C=1.
- OutReady held 0 for 5 cycles after a result → ALUOut/FlagsOut stable, InReady 0. Release → pop and next op accepted on the same edge.
- Reset pulsed at cycle 7 of a MUL → OutValid 0, FlagsOut 0, Busy 0; the next op completes normally.
